// File: rtl/transpose_tile_loader.sv
// Double-buffered tile loader: fills one NUM_PE x NUM_PE bank row-by-row while the
// other bank drains as (row, next row) beat pairs toward the transpose switch stage.

module transpose_tile_lane #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic                      i_wbank,
  input  logic [$clog2(NUM_PE)-1:0] i_wrow,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic                      i_rvalid,
  input  logic                      i_rbank,
  input  logic [$clog2(NUM_PE)-1:0] i_rrow_down,
  input  logic [$clog2(NUM_PE)-1:0] i_rrow_across,
  output logic [DATA_WIDTH-1:0]     o_down,
  output logic [DATA_WIDTH-1:0]     o_across
);
  // One PE column of both banks; storage is never reset, validity lives in the full flags.
  logic [DATA_WIDTH-1:0] r_mem [2][NUM_PE];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wbank][i_wrow] <= i_wdata;
  end

  assign o_down   = i_rvalid ? r_mem[i_rbank][i_rrow_down]   : '0;
  assign o_across = i_rvalid ? r_mem[i_rbank][i_rrow_across] : '0;
endmodule

module transpose_tile_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                transpose_en,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [0:NUM_PE-1][DATA_WIDTH-1:0]   in_row,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [0:NUM_PE-1][DATA_WIDTH-1:0]   out_down,
  output logic [0:NUM_PE-1][DATA_WIDTH-1:0]   out_across,
  output logic                                out_ctrl,
  output logic                                out_last
);
  localparam int RW = $clog2(NUM_PE);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_PE - 1);

  logic [1:0]    r_full;
  logic [1:0]    r_ctrl;
  logic          r_fill_bank;
  logic          r_drain_bank;
  logic [RW-1:0] r_fill_row;
  logic [RW-1:0] r_drain_row;

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_fill_done;
  logic          w_drain_done;
  logic [RW-1:0] w_across_row;

  assign in_ready     = !r_full[r_fill_bank];
  assign out_valid    = r_full[r_drain_bank];
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;
  assign w_fill_done  = w_in_fire && (r_fill_row == LAST_ROW);
  assign w_drain_done = w_out_fire && (r_drain_row == LAST_ROW);
  assign w_across_row = r_drain_row + RW'(1);

  assign out_ctrl = out_valid && r_ctrl[r_drain_bank];
  assign out_last = out_valid && (r_drain_row == LAST_ROW);

  // Fill and drain pointers advance independently; a bank is handed over only via its full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_bank  <= 1'b0;
      r_fill_row   <= '0;
      r_drain_bank <= 1'b0;
      r_drain_row  <= '0;
      r_ctrl       <= '0;
    end else begin
      if (w_in_fire) begin
        r_fill_row <= r_fill_row + RW'(1);
        if (r_fill_row == '0) r_ctrl[r_fill_bank] <= transpose_en;
        if (w_fill_done) r_fill_bank <= !r_fill_bank;
      end
      if (w_out_fire) begin
        r_drain_row <= r_drain_row + RW'(1);
        if (w_drain_done) r_drain_bank <= !r_drain_bank;
      end
    end
  end

  // Set and clear can never target the same bank: set needs it empty, clear needs it full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_fill_done && (r_fill_bank == 1'(b)))
          r_full[b] <= 1'b1;
        else if (w_drain_done && (r_drain_bank == 1'(b)))
          r_full[b] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    transpose_tile_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_PE     (NUM_PE)
    ) u_lane (
      .clk           (clk),
      .i_we          (w_in_fire),
      .i_wbank       (r_fill_bank),
      .i_wrow        (r_fill_row),
      .i_wdata       (in_row[g]),
      .i_rvalid      (out_valid),
      .i_rbank       (r_drain_bank),
      .i_rrow_down   (r_drain_row),
      .i_rrow_across (w_across_row),
      .o_down        (out_down[g]),
      .o_across      (out_across[g])
    );
  end
endmodule
